// File: rtl/regfile_wb_buffer.sv
// Writeback merge buffer: folds up to two writebacks per cycle (MEM older, ALU younger) into the
// single regfile write port through an in-order FIFO, with a two-port bypass lookup for ID reads.
module regfile_wb_buffer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_waddr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  input  logic              alu_we_i,
  input  logic [ADDR_W-1:0] alu_waddr_i,
  input  logic [DATA_W-1:0] alu_wdata_i,
  output logic              in_ready_o,
  output logic              overflow_o,
  output logic              rf_we_o,
  output logic [ADDR_W-1:0] rf_waddr_o,
  output logic [DATA_W-1:0] rf_wdata_o,
  input  logic [ADDR_W-1:0] q1_addr_i,
  output logic              q1_hit_o,
  output logic [DATA_W-1:0] q1_data_o,
  input  logic [ADDR_W-1:0] q2_addr_i,
  output logic              q2_hit_o,
  output logic [DATA_W-1:0] q2_data_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

  logic              in_ready;
  logic              mem_req, alu_req, mem_acc, alu_acc;
  logic [1:0]        n_acc;
  logic [ADDR_W-1:0] first_a, second_a;
  logic [DATA_W-1:0] first_d, second_d;
  logic [1:0]        enq_n;
  logic [ADDR_W-1:0] enq_a [2];
  logic [DATA_W-1:0] enq_d [2];

  assign in_ready = (count_q <= CntW'(DEPTH - 2));
  // Writes to r0 are architecturally void, so they neither enqueue nor trip overflow.
  assign mem_req  = mem_we_i && (mem_waddr_i != '0);
  assign alu_req  = alu_we_i && (alu_waddr_i != '0);
  assign mem_acc  = mem_req && in_ready;
  assign alu_acc  = alu_req && in_ready;

  always_comb begin
    n_acc    = 2'(mem_acc) + 2'(alu_acc);
    first_a  = mem_acc ? mem_waddr_i : alu_waddr_i;
    first_d  = mem_acc ? mem_wdata_i : alu_wdata_i;
    second_a = alu_waddr_i;
    second_d = alu_wdata_i;
  end

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    enq_n      = 2'd0;
    enq_a[0]   = first_a;
    enq_d[0]   = first_d;
    enq_a[1]   = second_a;
    enq_d[1]   = second_d;
    ovf_d      = ovf_q | (!in_ready && (mem_req || alu_req));

    if (count_q != '0) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = addr_mem[rd_ptr_q];
      rf_wdata_d = data_mem[rd_ptr_q];
      rd_ptr_d   = rd_ptr_q + 1'b1;
      enq_n      = n_acc;
      count_d    = count_q + CntW'(n_acc) - 1'b1;
    end else if (n_acc != 2'd0) begin
      // Empty FIFO: the oldest push bypasses straight to the write port.
      rf_we_d    = 1'b1;
      rf_waddr_d = first_a;
      rf_wdata_d = first_d;
      enq_n      = n_acc - 2'd1;
      enq_a[0]   = second_a;
      enq_d[0]   = second_d;
      count_d    = CntW'(n_acc - 2'd1);
    end
    wr_ptr_d = wr_ptr_q + PtrW'(enq_n);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  // Storage needs no reset: only entries covered by count_q are ever observed.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (enq_n != 2'd0) begin
        addr_mem[wr_ptr_q] <= enq_a[0];
        data_mem[wr_ptr_q] <= enq_d[0];
      end
      if (enq_n == 2'd2) begin
        addr_mem[wr_ptr_q + 1'b1] <= enq_a[1];
        data_mem[wr_ptr_q + 1'b1] <= enq_d[1];
      end
    end
  end

  logic [ADDR_W-1:0] q_addr [2];
  logic              q_hit  [2];
  logic [DATA_W-1:0] q_data [2];
  logic [PtrW-1:0]   idx;

  assign q_addr[0] = q1_addr_i;
  assign q_addr[1] = q2_addr_i;

  // Oldest-to-youngest scan with overwrite, so the youngest pending match wins.
  always_comb begin
    idx = '0;
    for (int p = 0; p < 2; p++) begin
      q_hit[p]  = 1'b0;
      q_data[p] = '0;
      if (q_addr[p] != '0) begin
        if (rf_we_q && (rf_waddr_q == q_addr[p])) begin
          q_hit[p]  = 1'b1;
          q_data[p] = rf_wdata_q;
        end
        for (int i = 0; i < DEPTH; i++) begin
          idx = rd_ptr_q + PtrW'(i);
          if ((CntW'(i) < count_q) && (addr_mem[idx] == q_addr[p])) begin
            q_hit[p]  = 1'b1;
            q_data[p] = data_mem[idx];
          end
        end
      end
    end
  end

  assign in_ready_o = in_ready;
  assign overflow_o = ovf_q;
  assign rf_we_o    = rf_we_q;
  assign rf_waddr_o = rf_waddr_q;
  assign rf_wdata_o = rf_wdata_q;
  assign q1_hit_o   = q_hit[0];
  assign q1_data_o  = q_data[0];
  assign q2_hit_o   = q_hit[1];
  assign q2_data_o  = q_data[1];

endmodule

// File: tb/tb_regfile_wb_buffer.sv
// Bench for regfile_wb_buffer: queue-based reference model checked every cycle, plus directed
// scenarios with literal expectations.
module tb_regfile_wb_buffer;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DEPTH  = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  logic mem_we, alu_we;
  logic [ADDR_W-1:0] mem_waddr, alu_waddr, q1_addr, q2_addr;
  logic [DATA_W-1:0] mem_wdata, alu_wdata;
  logic in_ready, overflow, rf_we, q1_hit, q2_hit;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata, q1_data, q2_data;

  always #5 clk = ~clk;

  regfile_wb_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .mem_we_i(mem_we), .mem_waddr_i(mem_waddr), .mem_wdata_i(mem_wdata),
    .alu_we_i(alu_we), .alu_waddr_i(alu_waddr), .alu_wdata_i(alu_wdata),
    .in_ready_o(in_ready), .overflow_o(overflow),
    .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
    .q1_addr_i(q1_addr), .q1_hit_o(q1_hit), .q1_data_o(q1_data),
    .q2_addr_i(q2_addr), .q2_hit_o(q2_hit), .q2_data_o(q2_data)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  ent_t              m_fifo[$];
  logic              m_rf_we;
  logic [ADDR_W-1:0] m_rf_a;
  logic [DATA_W-1:0] m_rf_d;
  logic              m_ovf;
  bit                model_check_en = 0;

  task automatic chk(input string name, input logic [DATA_W-1:0] act,
                     input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic m_ready();
    return m_fifo.size() <= DEPTH - 2;
  endfunction

  // Youngest pending value for a register: FIFO back-to-front, then the output stage.
  function automatic logic [DATA_W:0] m_lookup(input logic [ADDR_W-1:0] a);
    if (a == 0) return '0;
    for (int i = m_fifo.size() - 1; i >= 0; i--)
      if (m_fifo[i].a == a) return {1'b1, m_fifo[i].d};
    if (m_rf_we && m_rf_a == a) return {1'b1, m_rf_d};
    return '0;
  endfunction

  task automatic m_reset();
    m_fifo.delete();
    m_rf_we = 0; m_rf_a = '0; m_rf_d = '0; m_ovf = 0;
  endtask

  task automatic m_clock();
    ent_t acc[$];
    if (rst) begin
      m_reset();
      return;
    end
    if (m_ready()) begin
      if (mem_we && mem_waddr != 0) acc.push_back('{mem_waddr, mem_wdata});
      if (alu_we && alu_waddr != 0) acc.push_back('{alu_waddr, alu_wdata});
    end else if ((mem_we && mem_waddr != 0) || (alu_we && alu_waddr != 0)) begin
      m_ovf = 1;
    end
    if (m_fifo.size() > 0) begin
      ent_t h = m_fifo.pop_front();
      m_rf_we = 1; m_rf_a = h.a; m_rf_d = h.d;
      foreach (acc[i]) m_fifo.push_back(acc[i]);
    end else if (acc.size() > 0) begin
      m_rf_we = 1; m_rf_a = acc[0].a; m_rf_d = acc[0].d;
      for (int i = 1; i < acc.size(); i++) m_fifo.push_back(acc[i]);
    end else begin
      m_rf_we = 0;
    end
  endtask

  // Compare process: DUT against the model on every falling edge.
  always @(negedge clk) begin
    if (model_check_en) begin
      logic [DATA_W:0] l1, l2;
      l1 = m_lookup(q1_addr);
      l2 = m_lookup(q2_addr);
      chk("m_rf_we",    32'(rf_we),    32'(m_rf_we));
      chk("m_rf_waddr", 32'(rf_waddr), 32'(m_rf_a));
      chk("m_rf_wdata", rf_wdata,      m_rf_d);
      chk("m_in_ready", 32'(in_ready), 32'(m_ready()));
      chk("m_overflow", 32'(overflow), 32'(m_ovf));
      chk("m_q1_hit",   32'(q1_hit),   32'(l1[DATA_W]));
      chk("m_q1_data",  q1_data,       l1[DATA_W-1:0]);
      chk("m_q2_hit",   32'(q2_hit),   32'(l2[DATA_W]));
      chk("m_q2_data",  q2_data,       l2[DATA_W-1:0]);
    end
  end

  task automatic step();
    @(posedge clk);
    m_clock();
    #1;
  endtask

  task automatic idle();
    mem_we = 0; alu_we = 0;
    mem_waddr = '0; alu_waddr = '0; mem_wdata = '0; alu_wdata = '0;
  endtask

  task automatic push(input logic mw, input logic [ADDR_W-1:0] ma, input logic [DATA_W-1:0] md,
                      input logic aw, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad);
    mem_we = mw; mem_waddr = ma; mem_wdata = md;
    alu_we = aw; alu_waddr = aa; alu_wdata = ad;
  endtask

  initial begin
    rst = 1; idle(); q1_addr = '0; q2_addr = '0;
    m_reset();
    step(); step();
    rst = 0;
    model_check_en = 1;
    step();
    chk("rst_rf_we", 32'(rf_we), 0);
    chk("rst_rf_waddr", 32'(rf_waddr), 0);
    chk("rst_rf_wdata", rf_wdata, 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_overflow", 32'(overflow), 0);

    // Single push: written next cycle, idle the cycle after, address held.
    push(1, 5'd3, 32'h11, 0, 5'd0, 0);
    step(); idle();
    chk("single_we", 32'(rf_we), 1);
    chk("single_addr", 32'(rf_waddr), 3);
    chk("single_data", rf_wdata, 32'h11);
    step();
    chk("single_we_off", 32'(rf_we), 0);
    chk("single_addr_hold", 32'(rf_waddr), 3);

    // Dual push: r4 then r5 on consecutive cycles.
    push(1, 5'd4, 32'hA, 1, 5'd5, 32'hB);
    step(); idle();
    chk("dual_first", 32'(rf_waddr), 4);
    chk("dual_first_d", rf_wdata, 32'hA);
    step();
    chk("dual_second_we", 32'(rf_we), 1);
    chk("dual_second", 32'(rf_waddr), 5);
    step();

    // Bypass: r7=1 in output stage, younger r7=2 in FIFO.
    push(1, 5'd7, 32'h1, 1, 5'd7, 32'h2);
    step(); idle();
    q1_addr = 5'd7; q2_addr = 5'd8;
    #1;
    chk("byp_q1_hit", 32'(q1_hit), 1);
    chk("byp_q1_data", q1_data, 32'h2);
    chk("byp_q2_hit", 32'(q2_hit), 0);
    chk("byp_q2_data", q2_data, 0);
    step(); step();

    // r0 writes are discarded.
    push(0, 5'd0, 0, 1, 5'd0, 32'hFF);
    q1_addr = 5'd0;
    step(); idle();
    chk("r0_we", 32'(rf_we), 0);
    chk("r0_ovf", 32'(overflow), 0);
    chk("r0_q1_hit", 32'(q1_hit), 0);

    // Three dual pushes fill to 3, fourth overflows; six writes drain in order.
    for (int k = 0; k < 3; k++) begin
      push(1, 5'(2*k+10), 32'(100+2*k), 1, 5'(2*k+11), 32'(101+2*k));
      step();
    end
    chk("fill_in_ready_low", 32'(in_ready), 0);
    push(1, 5'd20, 32'hDEAD, 1, 5'd21, 32'hBEEF);
    step(); idle();
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_in_ready_back", 32'(in_ready), 1);
    for (int k = 3; k < 6; k++) begin
      chk("drain_order", 32'(rf_waddr), 32'(k+10));
      step();
    end
    chk("drain_done", 32'(rf_we), 0);
    chk("ovf_sticky", 32'(overflow), 1);

    // Reset mid-operation drops everything.
    push(1, 5'd1, 32'h5, 1, 5'd2, 32'h6);
    step();
    push(1, 5'd3, 32'h7, 1, 5'd4, 32'h8);
    step(); idle();
    rst = 1;
    step();
    rst = 0;
    chk("mrst_we", 32'(rf_we), 0);
    chk("mrst_ready", 32'(in_ready), 1);
    chk("mrst_ovf", 32'(overflow), 0);
    step();
    chk("mrst_no_stale", 32'(rf_we), 0);

    // Random traffic, mostly honouring in_ready, with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      logic obey;
      obey = ($urandom_range(0, 9) != 0);
      if (obey && !m_ready()) idle();
      else push($urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom,
                $urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom);
      q1_addr = 5'($urandom_range(0, 7));
      q2_addr = 5'($urandom_range(0, 7));
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 0; idle();
    step(); step();
    model_check_en = 0;
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
